rvv_backend_decode_ctrl: RTL and testbench
==========================================

Name: rvv_backend_decode_ctrl

Overview:
- Sequencing controller on the command-queue side of the RVV decoder.
- Tracks how many uops of the head instruction have already been pushed, and drives that count back to the decoder as uop_index_remain.
- Grants per-slot pushes into the Uops Queue based on free space, and pops the command queue once the last uop of the instruction has been pushed.
- Sits between the command queue, the decoder and the Uops Queue. The decoder is combinational, so this block holds all decode-stage state.

Parameters:
- NUM_DE_UOP, 4: decoded uop slots per cycle.
- UOP_INDEX_WIDTH, 3: width of uop index; an instruction has at most 2^UOP_INDEX_WIDTH uops.
- UQ_FREE_WIDTH, 4: width of the Uops Queue free-slot count.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- inst_valid_cq2de  input  1  command queue head is valid.
- uop_valid_de2uq  input  NUM_DE_UOP  per-slot uop valid from the decoder.
- uop_last_de2uq  input  NUM_DE_UOP  per-slot flag: this uop is the last uop of the instruction.
- uq_free_cnt  input  UQ_FREE_WIDTH  free entries in the Uops Queue this cycle.
- trap_flush_rvv  input  1  flush; abandon the current instruction.
- uop_index_remain  output  UOP_INDEX_WIDTH  index of the next uop to decode (registered).
- push_de2uq  output  NUM_DE_UOP  per-slot push enable to the Uops Queue.
- pop_de2cq  output  1  pop the command queue head.
- decode_err  output  1  one-cycle pulse: malformed uop stream was discarded (registered).

Behaviour:
- Clock and reset: one clock (clk). rst_n is asynchronous and active-low.
- Reset values: uop_index_remain=0, decode_err=0.
- push_de2uq and pop_de2cq are combinational. Both are 0 whenever inst_valid_cq2de=0 or trap_flush_rvv=1.
- Push grant: push_de2uq[i] = inst_valid & uop_valid_de2uq[i] & (i < uq_free_cnt) & no uop_last_de2uq[j] for j<i.
  - Slots at or below the first last-flagged slot may push; slots after it never push.
  - Valid slots are contiguous from slot 0 (asserted). The grant is therefore a prefix; n = number of granted slots.
- Last pushed: last_pushed = OR over i of (push_de2uq[i] & uop_last_de2uq[i]).
- Overflow: sum = uop_index_remain + n, computed at UOP_INDEX_WIDTH+1 bits. overflow = (sum > 2^UOP_INDEX_WIDTH-1) & !last_pushed.
- pop_de2cq = inst_valid & !trap_flush_rvv & (last_pushed | overflow).
- Next-state priority (highest first):
  1. trap_flush_rvv: remain <= 0, no push, no pop.
  2. last_pushed: remain <= 0.
  3. overflow: remain <= 0, decode_err <= 1 next cycle. The instruction is popped and discarded, with no trap.
  4. n>0: remain <= sum[UOP_INDEX_WIDTH-1:0].
  5. else: hold.
- decode_err is 0 in every cycle not following an overflow.
- Stall: uq_free_cnt=0 with a valid instruction gives n=0; remain holds and there is no pop.
- Partial accept: uq_free_cnt < decoded uops pushes only the first uq_free_cnt slots. The next cycle re-decodes from the updated remain.
- uq_free_cnt >= NUM_DE_UOP is treated as NUM_DE_UOP.
- inst_valid low: remain holds (normally 0 between instructions).
- Reset mid-instruction: remain returns to 0 immediately. The CQ head is re-decoded from uop 0 after reset.
- Latency: the pop is issued in the same cycle as the last push. The next instruction decodes the following cycle with remain=0.
- Assertions (sim only):
  - uop_valid_de2uq is a contiguous prefix.
  - uop_last_de2uq[i] implies uop_valid_de2uq[i].
  - push_de2uq never exceeds uq_free_cnt.

Optional Feature:
- Macro: RVV_DECODE_STALL_CNT_EN.
- Defined:
  - Adds output port decode_stall_cnt, 32 bits. It increments by 1 each cycle with inst_valid_cq2de=1, no trap_flush_rvv, and n=0, saturating at 0xFFFFFFFF.
  - Reset value 0; trap_flush_rvv does not clear it.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- 1 uop instruction: valid=0001, last=0001, free=8 -> push=0001, pop=1 same cycle, remain stays 0.
- 8 uop instruction, free=8:
  - Cycle 1: valid=1111, last=0000 -> push=1111, remain=4 next cycle.
  - Cycle 2: valid=1111, last=1000 -> push=1111, pop=1, remain=0.
- Partial accept: 6 uop instruction, free=2 then free=8.
  - Cycle 1: push=0011, remain=2.
  - Cycle 2: valid=1111, last=1000 -> push=1111, pop=1, remain=0.
- Stall then flush: free=0 for 3 cycles -> push=0, pop=0, remain holds at 4; trap_flush_rvv=1 -> remain=0, no pop. With RVV_DECODE_STALL_CNT_EN, decode_stall_cnt=3.
- Overflow: remain=6, valid=0111, last=0000, free=8 -> pop=1, remain=0, decode_err=1 for exactly one cycle.
- Async reset asserted mid-instruction with remain=4 -> remain=0 and decode_err=0 immediately, without a clock edge. The instruction re-decodes from index 0 after rst_n rises.

Source files
------------

// File: rtl/rvv_backend_decode_ctrl.sv
// rtl/rvv_backend_decode_ctrl.sv - decode-stage sequencing controller between command queue, decoder and Uops Queue
//
// Purpose: holds the uop progress of the command-queue head instruction,
// grants per-slot pushes into the Uops Queue and pops the command queue
// once the last uop has been pushed (or a malformed stream overflows).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   inst_valid_cq2de    command queue head valid
//   uop_valid_de2uq     per-slot decoded uop valid (contiguous prefix)
//   uop_last_de2uq      per-slot last-uop-of-instruction flag
//   uq_free_cnt         free entries in the Uops Queue
//   trap_flush_rvv      flush, abandon the current instruction
//   uop_index_remain    registered index of the next uop to decode
//   push_de2uq          per-slot push enable (combinational)
//   pop_de2cq           pop command queue head (combinational)
//   decode_err          registered one-cycle pulse on overflow discard
//   decode_stall_cnt    saturating stall counter, only with RVV_DECODE_STALL_CNT_EN
//
// Optional feature macro: RVV_DECODE_STALL_CNT_EN

module rvv_backend_decode_ctrl #(
  parameter int NUM_DE_UOP      = 4,
  parameter int UOP_INDEX_WIDTH = 3,
  parameter int UQ_FREE_WIDTH   = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       inst_valid_cq2de,
  input  logic [NUM_DE_UOP-1:0]      uop_valid_de2uq,
  input  logic [NUM_DE_UOP-1:0]      uop_last_de2uq,
  input  logic [UQ_FREE_WIDTH-1:0]   uq_free_cnt,
  input  logic                       trap_flush_rvv,
  output logic [UOP_INDEX_WIDTH-1:0] uop_index_remain,
  output logic [NUM_DE_UOP-1:0]      push_de2uq,
  output logic                       pop_de2cq,
  output logic                       decode_err
`ifdef RVV_DECODE_STALL_CNT_EN
  ,
  output logic [31:0]                decode_stall_cnt
`endif
);

  localparam logic [UOP_INDEX_WIDTH:0] MAX_INDEX = {1'b0, {UOP_INDEX_WIDTH{1'b1}}};

  logic                       active;
  logic                       blocked;
  logic [NUM_DE_UOP-1:0]      grant;
  logic [UOP_INDEX_WIDTH:0]   n;
  logic [UOP_INDEX_WIDTH:0]   sum;
  logic                       last_pushed;
  logic                       overflow;
  logic [UOP_INDEX_WIDTH-1:0] remain_next;
  logic                       err_next;

  assign active = inst_valid_cq2de & ~trap_flush_rvv;

  // Grant is a prefix: a slot pushes only if it is valid, fits in the free
  // space and no earlier slot already carried the last uop. Comparing against
  // the raw free count makes any count >= NUM_DE_UOP behave as NUM_DE_UOP.
  always_comb begin
    grant   = '0;
    blocked = 1'b0;
    n       = '0;
    for (int i = 0; i < NUM_DE_UOP; i++) begin
      grant[i] = active & uop_valid_de2uq[i] & ~blocked &
                 (i < 32'(uq_free_cnt));
      blocked  = blocked | uop_last_de2uq[i];
      n        = n + (UOP_INDEX_WIDTH+1)'(grant[i]);
    end
  end

  assign push_de2uq  = grant;
  assign last_pushed = |(grant & uop_last_de2uq);
  assign sum         = {1'b0, uop_index_remain} + n;
  // An instruction that runs past the index space without a last flag is
  // malformed; it is popped and dropped rather than trapped.
  assign overflow    = (sum > MAX_INDEX) & ~last_pushed;
  assign pop_de2cq   = active & (last_pushed | overflow);

  always_comb begin
    remain_next = uop_index_remain;
    err_next    = 1'b0;
    if (trap_flush_rvv) begin
      remain_next = '0;
    end else if (last_pushed) begin
      remain_next = '0;
    end else if (overflow) begin
      remain_next = '0;
      err_next    = 1'b1;
    end else if (n != '0) begin
      remain_next = sum[UOP_INDEX_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uop_index_remain <= '0;
      decode_err       <= 1'b0;
    end else begin
      uop_index_remain <= remain_next;
      decode_err       <= err_next;
    end
  end

`ifdef RVV_DECODE_STALL_CNT_EN
  // Counts cycles where a live instruction made no progress; flush does not clear it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      decode_stall_cnt <= '0;
    end else if (active && (n == '0) && (decode_stall_cnt != 32'hFFFF_FFFF)) begin
      decode_stall_cnt <= decode_stall_cnt + 32'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  logic [NUM_DE_UOP:0] valid_plus1;
  assign valid_plus1 = {1'b0, uop_valid_de2uq} + {{NUM_DE_UOP{1'b0}}, 1'b1};

  a_valid_prefix: assert property (@(posedge clk) disable iff (!rst_n)
    inst_valid_cq2de |-> ((valid_plus1[NUM_DE_UOP-1:0] & uop_valid_de2uq) == '0));

  a_last_has_valid: assert property (@(posedge clk) disable iff (!rst_n)
    inst_valid_cq2de |-> ((uop_last_de2uq & ~uop_valid_de2uq) == '0));

  a_push_fits: assert property (@(posedge clk) disable iff (!rst_n)
    32'(n) <= 32'(uq_free_cnt));
`endif

endmodule

// File: tb/tb_rvv_backend_decode_ctrl.sv
// tb/tb_rvv_backend_decode_ctrl.sv - self-checking bench for rvv_backend_decode_ctrl

module tb_rvv_backend_decode_ctrl;

  logic       clk;
  logic       rst_n;
  logic       inst_valid_cq2de;
  logic [3:0] uop_valid_de2uq;
  logic [3:0] uop_last_de2uq;
  logic [3:0] uq_free_cnt;
  logic       trap_flush_rvv;
  logic [2:0] uop_index_remain;
  logic [3:0] push_de2uq;
  logic       pop_de2cq;
  logic       decode_err;
`ifdef RVV_DECODE_STALL_CNT_EN
  logic [31:0] decode_stall_cnt;
`endif

  int errors = 0;
  int checks = 0;

  rvv_backend_decode_ctrl #(
    .NUM_DE_UOP(4),
    .UOP_INDEX_WIDTH(3),
    .UQ_FREE_WIDTH(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .inst_valid_cq2de(inst_valid_cq2de),
    .uop_valid_de2uq(uop_valid_de2uq),
    .uop_last_de2uq(uop_last_de2uq),
    .uq_free_cnt(uq_free_cnt),
    .trap_flush_rvv(trap_flush_rvv),
    .uop_index_remain(uop_index_remain),
    .push_de2uq(push_de2uq),
    .pop_de2cq(pop_de2cq),
    .decode_err(decode_err)
`ifdef RVV_DECODE_STALL_CNT_EN
    ,
    .decode_stall_cnt(decode_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; combinational outputs are sampled 1ns later.
  task automatic drive(input logic iv, input logic [3:0] v, input logic [3:0] l,
                       input logic [3:0] free, input logic fl);
    @(negedge clk);
    inst_valid_cq2de = iv;
    uop_valid_de2uq  = v;
    uop_last_de2uq   = l;
    uq_free_cnt      = free;
    trap_flush_rvv   = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    inst_valid_cq2de = 1'b0;
    uop_valid_de2uq  = 4'b0;
    uop_last_de2uq   = 4'b0;
    uq_free_cnt      = 4'd0;
    trap_flush_rvv   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    drive(1'b0, 4'b0, 4'b0, 4'd8, 1'b0);
    checks++; if (uop_index_remain !== 3'd0) begin errors++; $display("FAIL reset_remain got=%0d exp=0", uop_index_remain); end
    checks++; if (decode_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%0b exp=0", decode_err); end
    checks++; if (push_de2uq !== 4'b0 || pop_de2cq !== 1'b0) begin errors++; $display("FAIL idle_outputs push=%b pop=%b exp 0000/0", push_de2uq, pop_de2cq); end
  endtask

  task automatic test_one_uop();
    drive(1'b1, 4'b0001, 4'b0001, 4'd8, 1'b0);
    checks++; if (push_de2uq !== 4'b0001) begin errors++; $display("FAIL one_uop_push got=%b exp=0001", push_de2uq); end
    checks++; if (pop_de2cq !== 1'b1) begin errors++; $display("FAIL one_uop_pop got=%b exp=1", pop_de2cq); end
    tick();
    checks++; if (uop_index_remain !== 3'd0) begin errors++; $display("FAIL one_uop_remain got=%0d exp=0", uop_index_remain); end
  endtask

  task automatic test_eight_uop();
    drive(1'b1, 4'b1111, 4'b0000, 4'd8, 1'b0);
    checks++; if (push_de2uq !== 4'b1111 || pop_de2cq !== 1'b0) begin errors++; $display("FAIL eight_c1 push=%b pop=%b exp 1111/0", push_de2uq, pop_de2cq); end
    tick();
    checks++; if (uop_index_remain !== 3'd4) begin errors++; $display("FAIL eight_remain1 got=%0d exp=4", uop_index_remain); end
    drive(1'b1, 4'b1111, 4'b1000, 4'd8, 1'b0);
    checks++; if (push_de2uq !== 4'b1111 || pop_de2cq !== 1'b1) begin errors++; $display("FAIL eight_c2 push=%b pop=%b exp 1111/1", push_de2uq, pop_de2cq); end
    tick();
    checks++; if (uop_index_remain !== 3'd0) begin errors++; $display("FAIL eight_remain2 got=%0d exp=0", uop_index_remain); end
  endtask

  task automatic test_partial_accept();
    drive(1'b1, 4'b1111, 4'b0000, 4'd2, 1'b0);
    checks++; if (push_de2uq !== 4'b0011 || pop_de2cq !== 1'b0) begin errors++; $display("FAIL partial_c1 push=%b pop=%b exp 0011/0", push_de2uq, pop_de2cq); end
    tick();
    checks++; if (uop_index_remain !== 3'd2) begin errors++; $display("FAIL partial_remain1 got=%0d exp=2", uop_index_remain); end
    drive(1'b1, 4'b1111, 4'b1000, 4'd8, 1'b0);
    checks++; if (push_de2uq !== 4'b1111 || pop_de2cq !== 1'b1) begin errors++; $display("FAIL partial_c2 push=%b pop=%b exp 1111/1", push_de2uq, pop_de2cq); end
    tick();
    checks++; if (uop_index_remain !== 3'd0) begin errors++; $display("FAIL partial_remain2 got=%0d exp=0", uop_index_remain); end
  endtask

  task automatic test_stall_flush();
    do_reset();
    drive(1'b1, 4'b1111, 4'b0000, 4'd8, 1'b0);
    tick();
    checks++; if (uop_index_remain !== 3'd4) begin errors++; $display("FAIL stall_pre_remain got=%0d exp=4", uop_index_remain); end
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 4'b1111, 4'b0000, 4'd0, 1'b0);
      checks++; if (push_de2uq !== 4'b0 || pop_de2cq !== 1'b0) begin errors++; $display("FAIL stall_out cyc=%0d push=%b pop=%b exp 0000/0", c, push_de2uq, pop_de2cq); end
      tick();
      checks++; if (uop_index_remain !== 3'd4) begin errors++; $display("FAIL stall_remain cyc=%0d got=%0d exp=4", c, uop_index_remain); end
    end
    drive(1'b1, 4'b1111, 4'b0000, 4'd8, 1'b1);
    checks++; if (push_de2uq !== 4'b0 || pop_de2cq !== 1'b0) begin errors++; $display("FAIL flush_out push=%b pop=%b exp 0000/0", push_de2uq, pop_de2cq); end
    tick();
    checks++; if (uop_index_remain !== 3'd0) begin errors++; $display("FAIL flush_remain got=%0d exp=0", uop_index_remain); end
`ifdef RVV_DECODE_STALL_CNT_EN
    checks++; if (decode_stall_cnt !== 32'd3) begin errors++; $display("FAIL stall_cnt got=%0d exp=3", decode_stall_cnt); end
`endif
  endtask

  task automatic test_overflow();
    drive(1'b1, 4'b1111, 4'b0000, 4'd8, 1'b0);
    tick();
    drive(1'b1, 4'b0011, 4'b0000, 4'd8, 1'b0);
    checks++; if (pop_de2cq !== 1'b0) begin errors++; $display("FAIL ovf_pre_pop got=%b exp=0", pop_de2cq); end
    tick();
    checks++; if (uop_index_remain !== 3'd6) begin errors++; $display("FAIL ovf_pre_remain got=%0d exp=6", uop_index_remain); end
    drive(1'b1, 4'b0111, 4'b0000, 4'd8, 1'b0);
    checks++; if (push_de2uq !== 4'b0111 || pop_de2cq !== 1'b1) begin errors++; $display("FAIL ovf_out push=%b pop=%b exp 0111/1", push_de2uq, pop_de2cq); end
    checks++; if (decode_err !== 1'b0) begin errors++; $display("FAIL ovf_err_early got=%b exp=0", decode_err); end
    tick();
    checks++; if (uop_index_remain !== 3'd0 || decode_err !== 1'b1) begin errors++; $display("FAIL ovf_post remain=%0d err=%b exp 0/1", uop_index_remain, decode_err); end
    drive(1'b0, 4'b0000, 4'b0000, 4'd8, 1'b0);
    tick();
    checks++; if (decode_err !== 1'b0) begin errors++; $display("FAIL ovf_err_pulse got=%b exp=0", decode_err); end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 4'b1111, 4'b0000, 4'd8, 1'b0);
    tick();
    checks++; if (uop_index_remain !== 3'd4) begin errors++; $display("FAIL areset_pre got=%0d exp=4", uop_index_remain); end
    #2;
    rst_n = 1'b0;
    inst_valid_cq2de = 1'b0;
    uop_valid_de2uq  = 4'b0;
    uop_last_de2uq   = 4'b0;
    #1;
    checks++; if (uop_index_remain !== 3'd0 || decode_err !== 1'b0) begin errors++; $display("FAIL areset_now remain=%0d err=%b exp 0/0", uop_index_remain, decode_err); end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 4'b1111, 4'b0000, 4'd8, 1'b0);
    checks++; if (push_de2uq !== 4'b1111 || uop_index_remain !== 3'd0) begin errors++; $display("FAIL areset_redecode push=%b remain=%0d exp 1111/0", push_de2uq, uop_index_remain); end
    tick();
    checks++; if (uop_index_remain !== 3'd4) begin errors++; $display("FAIL areset_remain got=%0d exp=4", uop_index_remain); end
    drive(1'b1, 4'b1111, 4'b1000, 4'd8, 1'b0);
    tick();
    checks++; if (uop_index_remain !== 3'd0) begin errors++; $display("FAIL areset_done got=%0d exp=0", uop_index_remain); end
  endtask

  // Reference model: progress through the instruction is an integer count;
  // the accepted uop count is the smallest of valid uops, free space and the
  // position just past the first last-flagged uop.
  task automatic test_random();
    int m_remain;
    int m_err;
    int m_stall;
    do_reset();
    m_remain = 0;
    m_err    = 0;
    m_stall  = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic       iv, fl;
      logic [3:0] v, l, free;
      int nv, first_last, n, exp_push;
      bit lp, ovf, exp_pop;
      iv   = ($urandom_range(0, 9) != 0);
      fl   = ($urandom_range(0, 19) == 0);
      nv   = $urandom_range(0, 4);
      free = 4'($urandom_range(0, 15));
      v = 4'b0;
      l = 4'b0;
      first_last = 99;
      for (int i = 0; i < nv; i++) begin
        v[i] = 1'b1;
        if ($urandom_range(0, 5) == 0) begin
          l[i] = 1'b1;
          if (first_last == 99) first_last = i;
        end
      end
      n = 0;
      if (iv && !fl) begin
        n = nv;
        if (int'(free) < n) n = int'(free);
        if (first_last + 1 < n) n = first_last + 1;
      end
      lp       = (first_last < n);
      ovf      = !lp && (m_remain + n > 7);
      exp_push = (1 << n) - 1;
      exp_pop  = iv && !fl && (lp || ovf);

      drive(iv, v, l, free, fl);
      checks++; if (push_de2uq !== 4'(exp_push)) begin errors++; $display("FAIL rand_push cyc=%0d got=%b exp=%b", cyc, push_de2uq, 4'(exp_push)); end
      checks++; if (pop_de2cq !== exp_pop) begin errors++; $display("FAIL rand_pop cyc=%0d got=%b exp=%b", cyc, pop_de2cq, exp_pop); end

      if (fl || lp || ovf) m_remain = 0;
      else m_remain = m_remain + n;
      m_err = ovf ? 1 : 0;
      if (iv && !fl && n == 0) m_stall++;

      tick();
      checks++; if (uop_index_remain !== 3'(m_remain)) begin errors++; $display("FAIL rand_remain cyc=%0d got=%0d exp=%0d", cyc, uop_index_remain, m_remain); end
      checks++; if (decode_err !== 1'(m_err)) begin errors++; $display("FAIL rand_err cyc=%0d got=%b exp=%0d", cyc, decode_err, m_err); end
`ifdef RVV_DECODE_STALL_CNT_EN
      checks++; if (decode_stall_cnt !== 32'(m_stall)) begin errors++; $display("FAIL rand_stall cyc=%0d got=%0d exp=%0d", cyc, decode_stall_cnt, m_stall); end
`endif
    end
  endtask

  initial begin
    rst_n = 1'b0;
    inst_valid_cq2de = 1'b0;
    uop_valid_de2uq  = 4'b0;
    uop_last_de2uq   = 4'b0;
    uq_free_cnt      = 4'd0;
    trap_flush_rvv   = 1'b0;
    test_reset();
    test_one_uop();
    test_eight_uop();
    test_partial_accept();
    test_stall_flush();
    test_overflow();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
